// File: rtl/ipg_rx_demux_if.sv
// Block-level bus of the IPG receive demux: the RX block input, the block stream toward the
// decoder and the two extracted valid/ready streams.
interface ipg_rx_demux_if;
    logic        rx_valid;
    logic [1:0]  rx_hdr;
    logic [63:0] rx_data;
    logic        out_valid;
    logic [1:0]  out_hdr;
    logic [63:0] out_data;
    logic [63:0] mem_chunk;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] req_chunk;
    logic        req_valid;
    logic        req_ready;

    modport master (
        output rx_valid, rx_hdr, rx_data, mem_ready, req_ready,
        input  out_valid, out_hdr, out_data, mem_chunk, mem_valid, req_chunk, req_valid
    );

    modport slave (
        input  rx_valid, rx_hdr, rx_data, mem_ready, req_ready,
        output out_valid, out_hdr, out_data, mem_chunk, mem_valid, req_chunk, req_valid
    );
endinterface

// File: rtl/ipg_rx_demux.sv
// IPG receive demux: pulls memory-reply / read-request blocks out of idle gaps into two FWFT FIFOs,
// substitutes IDLE toward the 64b/66b decoder and tracks frame/gap state for protocol checking.
module ipg_rx_demux #(
    parameter logic [7:0] MEM_TYPE   = 8'hA5,
    parameter logic [7:0] REQ_TYPE   = 8'h5A,
    parameter int         FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               reset,
    ipg_rx_demux_if.slave      bus,
    output logic               in_frame,
    output logic [15:0]        drop_cnt,
    output logic               proto_err
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [63:0] IDLE_BLOCK = 64'h1E;
    localparam logic [1:0]  HDR_DATA   = 2'b10;
    localparam logic [1:0]  HDR_CTRL   = 2'b01;

    typedef enum logic {GAP, FRAME} state_t;

    state_t      state_q, state_d;
    logic        out_valid_q, out_valid_d;
    logic [1:0]  out_hdr_q, out_hdr_d;
    logic [63:0] out_data_q, out_data_d;
    logic        proto_err_q, proto_err_d;
    logic        in_frame_q, in_frame_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic [1:0]  push;
    logic [1:0]  pop;
    logic [1:0]  full;
    logic [1:0]  drop;
    logic [1:0]  fifo_valid;
    logic [1:0]  ready;
    logic [63:0] head [2];
    logic [7:0]  blk_type;

    assign blk_type = bus.rx_data[7:0];
    assign ready    = {bus.req_ready, bus.mem_ready};

    // Index 0 carries memory replies, index 1 read requests.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_fifo
            logic [63:0]      mem_q [FIFO_DEPTH];
            logic [PTR_W-1:0] wr_ptr_q;
            logic [PTR_W-1:0] rd_ptr_q;
            logic [CNT_W-1:0] cnt_q;
            logic             wr_en;

            assign full[gi]       = (cnt_q == CNT_W'(FIFO_DEPTH));
            assign fifo_valid[gi] = (cnt_q != '0);
            assign pop[gi]        = fifo_valid[gi] & ready[gi];
            // A pop in the same cycle frees the slot the full FIFO needs.
            assign wr_en          = push[gi] & (~full[gi] | pop[gi]);
            assign drop[gi]       = push[gi] & full[gi] & ~pop[gi];
            assign head[gi]       = mem_q[rd_ptr_q];

            always_ff @(posedge clk) begin
                if (wr_en) begin
                    mem_q[wr_ptr_q] <= bus.rx_data;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset) begin
                    wr_ptr_q <= '0;
                    rd_ptr_q <= '0;
                    cnt_q    <= '0;
                end else begin
                    if (wr_en) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    end
                    if (pop[gi]) begin
                        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                    end
                    case ({wr_en, pop[gi]})
                        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
                        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
                        default: cnt_q <= cnt_q;
                    endcase
                end
            end
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        out_hdr_d   = out_hdr_q;
        out_data_d  = out_data_q;
        proto_err_d = 1'b0;
        in_frame_d  = in_frame_q;
        push        = 2'b00;
        if (bus.rx_valid) begin
            out_valid_d = 1'b1;
            out_hdr_d   = bus.rx_hdr;
            out_data_d  = bus.rx_data;
            // in_frame reports the state that classified the block now on the output.
            in_frame_d  = (state_q == FRAME);
            if (bus.rx_hdr != HDR_CTRL && bus.rx_hdr != HDR_DATA) begin
                proto_err_d = 1'b1;
            end else begin
                case (state_q)
                    GAP: begin
                        if (bus.rx_hdr == HDR_DATA) begin
                            proto_err_d = 1'b1;
                        end else if (blk_type == 8'h78 || blk_type == 8'h33) begin
                            state_d = FRAME;
                        end else if (blk_type == MEM_TYPE || blk_type == REQ_TYPE) begin
                            push[0]    = (blk_type == MEM_TYPE);
                            push[1]    = (blk_type == REQ_TYPE);
                            out_hdr_d  = HDR_CTRL;
                            out_data_d = IDLE_BLOCK;
                        end
                    end
                    FRAME: begin
                        if (bus.rx_hdr == HDR_CTRL) begin
                            if (blk_type inside {8'h87, 8'h99, 8'hAA, 8'hB4,
                                                 8'hCC, 8'hD2, 8'hE1, 8'hFF}) begin
                                state_d = GAP;
                            end else begin
                                proto_err_d = 1'b1;
                            end
                        end
                    end
                    default: state_d = GAP;
                endcase
            end
        end
    end

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if ((|drop) && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= GAP;
            out_valid_q <= 1'b0;
            out_hdr_q   <= HDR_CTRL;
            out_data_q  <= IDLE_BLOCK;
            proto_err_q <= 1'b0;
            in_frame_q  <= 1'b0;
            drop_cnt_q  <= 16'd0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_hdr_q   <= out_hdr_d;
            out_data_q  <= out_data_d;
            proto_err_q <= proto_err_d;
            in_frame_q  <= in_frame_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_hdr   = out_hdr_q;
    assign bus.out_data  = out_data_q;
    assign bus.mem_chunk = head[0];
    assign bus.mem_valid = fifo_valid[0];
    assign bus.req_chunk = head[1];
    assign bus.req_valid = fifo_valid[1];
    assign in_frame      = in_frame_q;
    assign drop_cnt      = drop_cnt_q;
    assign proto_err     = proto_err_q;
endmodule
